// File: rtl/acumulador_credito.sv
// ============================================================================
// acumulador_credito : coin-credit accumulator with ceiling, timeout and settle
// Rev 1.0
// ============================================================================
`default_nettype none

module acumulador_credito #(
  parameter int CREDIT_W    = 8,
  parameter int MAX_CREDIT  = 8,
  parameter int COIN1_VAL   = 1,
  parameter int COIN2_VAL   = 2,
  parameter int COIN3_VAL   = 4,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                moeda_valida,
  input  logic [1:0]          valorMoeda,
  input  logic [CREDIT_W-1:0] preco,
  input  logic                compra,
  input  logic                cancelar,
  output logic [CREDIT_W-1:0] valorAcumulado,
  output logic                comparar,
  output logic                liberar,
  output logic [CREDIT_W-1:0] troco,
  output logic                troco_valido,
  output logic                moeda_rejeitada,
  output logic                compra_negada,
  output logic                ocupado
);

  localparam int TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACUM    = 2'd1;
  localparam logic [1:0] S_VENDA   = 2'd2;
  localparam logic [1:0] S_DEVOLVE = 2'd3;

  localparam logic [CREDIT_W:0]   C_MAX      = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] C_COIN1    = CREDIT_W'(COIN1_VAL);
  localparam logic [CREDIT_W-1:0] C_COIN2    = CREDIT_W'(COIN2_VAL);
  localparam logic [CREDIT_W-1:0] C_COIN3    = CREDIT_W'(COIN3_VAL);
  localparam logic [TMR_W-1:0]    C_TMO_LAST = TMR_W'(TIMEOUT_CYC - 1);

  logic [1:0]          r_state, w_state_nx;
  logic [CREDIT_W-1:0] r_credit, w_credit_nx;
  logic [CREDIT_W-1:0] r_troco, w_troco_nx;
  logic [TMR_W-1:0]    r_timer, w_timer_nx;
  logic                r_comparar, r_liberar, r_tv, r_rej, r_neg, r_ocupado;
  logic                w_comparar, w_liberar, w_tv, w_rej, w_neg;

  logic [CREDIT_W-1:0] w_coin_val;
  logic [CREDIT_W:0]   w_sum;
  logic                w_coin, w_busy, w_cancel, w_buy_ok, w_buy_no;
  logic                w_tmo, w_term, w_accept;

  always_comb begin
    case (valorMoeda)
      2'b01:   w_coin_val = C_COIN1;
      2'b10:   w_coin_val = C_COIN2;
      2'b11:   w_coin_val = C_COIN3;
      default: w_coin_val = '0;
    endcase
  end

  // Event decode in priority order: cancelar > compra > timeout > coin.
  assign w_coin   = moeda_valida && (valorMoeda != 2'b00);
  assign w_sum    = {1'b0, r_credit} + {1'b0, w_coin_val};
  assign w_busy   = (r_state == S_VENDA) || (r_state == S_DEVOLVE);
  assign w_cancel = cancelar && (r_state == S_ACUM);
  assign w_buy_ok = compra && !w_busy && !w_cancel && (r_credit >= preco);
  assign w_buy_no = compra && !w_busy && !w_cancel && (r_credit < preco);
  // A denied compra freezes the timer, so it also defers the timeout.
  assign w_tmo    = (r_state == S_ACUM) && (r_timer == C_TMO_LAST) && !w_cancel && !compra;
  assign w_term   = w_cancel || w_buy_ok || w_tmo;
  assign w_accept = w_coin && !w_busy && !w_term && (w_sum <= C_MAX);

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_credit   <= '0;
      r_troco    <= '0;
      r_timer    <= '0;
      r_comparar <= 1'b0;
      r_liberar  <= 1'b0;
      r_tv       <= 1'b0;
      r_rej      <= 1'b0;
      r_neg      <= 1'b0;
      r_ocupado  <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_credit   <= w_credit_nx;
      r_troco    <= w_troco_nx;
      r_timer    <= w_timer_nx;
      r_comparar <= w_comparar;
      r_liberar  <= w_liberar;
      r_tv       <= w_tv;
      r_rej      <= w_rej;
      r_neg      <= w_neg;
      r_ocupado  <= (w_state_nx == S_VENDA) || (w_state_nx == S_DEVOLVE);
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE, S_ACUM: begin
        if (w_cancel)      w_state_nx = S_DEVOLVE;
        else if (w_buy_ok) w_state_nx = S_VENDA;
        else if (w_tmo)    w_state_nx = S_DEVOLVE;
        else if (w_accept) w_state_nx = S_ACUM;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Datapath and pulse outputs
  always_comb begin
    w_credit_nx = r_credit;
    w_troco_nx  = r_troco;
    w_timer_nx  = r_timer;
    w_comparar  = 1'b0;
    w_liberar   = 1'b0;
    w_tv        = 1'b0;
    w_neg       = w_buy_no;
    w_rej       = w_coin && !w_accept;
    if (w_busy) begin
      w_credit_nx = '0;
      w_timer_nx  = '0;
    end else if (w_cancel || w_tmo) begin
      w_troco_nx  = r_credit;
      w_tv        = 1'b1;
      w_comparar  = w_tmo;
      w_credit_nx = '0;
      w_timer_nx  = '0;
    end else if (w_buy_ok) begin
      w_troco_nx  = r_credit - preco;
      w_tv        = 1'b1;
      w_liberar   = 1'b1;
      w_credit_nx = '0;
      w_timer_nx  = '0;
    end else if (w_accept) begin
      w_credit_nx = w_sum[CREDIT_W-1:0];
      w_timer_nx  = '0;
    end else if ((r_state == S_ACUM) && !w_buy_no) begin
      w_timer_nx  = r_timer + TMR_W'(1);
    end
  end

  assign valorAcumulado  = r_credit;
  assign troco           = r_troco;
  assign comparar        = r_comparar;
  assign liberar         = r_liberar;
  assign troco_valido    = r_tv;
  assign moeda_rejeitada = r_rej;
  assign compra_negada   = r_neg;
  assign ocupado         = r_ocupado;

endmodule

`default_nettype wire

// File: tb/tb_acumulador_credito.sv
// ============================================================================
// tb_acumulador_credito : scoreboard bench for acumulador_credito
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_acumulador_credito;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       moeda_valida = 1'b0;
  logic [1:0] valorMoeda = 2'b00;
  logic [7:0] preco = 8'd0;
  logic       compra = 1'b0;
  logic       cancelar = 1'b0;
  logic [7:0] valorAcumulado, troco;
  logic       comparar, liberar, troco_valido, moeda_rejeitada, compra_negada, ocupado;

  typedef struct packed {
    logic [7:0] credit;
    logic [7:0] troco;
    logic       tv, lib, cmp, rej, neg, ocu;
  } out_t;

  out_t q_exp[$];
  out_t q_obs[$];
  out_t e, o;
  int   n_pass = 0;
  int   n_tot  = 0;

  acumulador_credito #(
    .CREDIT_W(8), .MAX_CREDIT(8), .COIN1_VAL(1), .COIN2_VAL(2), .COIN3_VAL(4), .TIMEOUT_CYC(10)
  ) dut (
    .clk(clk), .rst(rst), .moeda_valida(moeda_valida), .valorMoeda(valorMoeda),
    .preco(preco), .compra(compra), .cancelar(cancelar),
    .valorAcumulado(valorAcumulado), .comparar(comparar), .liberar(liberar),
    .troco(troco), .troco_valido(troco_valido), .moeda_rejeitada(moeda_rejeitada),
    .compra_negada(compra_negada), .ocupado(ocupado)
  );

  always #5 clk = ~clk;

  function automatic out_t ex(input int c, input int t, input logic tv, input logic lib,
                              input logic cmp, input logic rej, input logic neg, input logic ocu);
    out_t r;
    r.credit = 8'(c);
    r.troco  = 8'(t);
    r.tv = tv; r.lib = lib; r.cmp = cmp; r.rej = rej; r.neg = neg; r.ocu = ocu;
    return r;
  endfunction

  // One clock: drive inputs, push the expected result, sample the DUT after the edge.
  task automatic cyc(input logic mv, input logic [1:0] vm, input int pr, input logic cp,
                     input logic cn, input logic r, input out_t exp_o);
    @(negedge clk);
    moeda_valida = mv; valorMoeda = vm; preco = 8'(pr);
    compra = cp; cancelar = cn; rst = r;
    q_exp.push_back(exp_o);
    @(posedge clk);
    #1;
    q_obs.push_back({valorAcumulado, troco, troco_valido, liberar, comparar,
                     moeda_rejeitada, compra_negada, ocupado});
  endtask

  task automatic idle(input out_t exp_o);
    cyc(1'b0, 2'b00, 0, 1'b0, 1'b0, 1'b0, exp_o);
  endtask

  task automatic test_reset;
    cyc(1'b1, 2'b11, 3, 1'b1, 1'b1, 1'b1, ex(0, 0, 0, 0, 0, 0, 0, 0));
    idle(ex(0, 0, 0, 0, 0, 0, 0, 0));
    cyc(1'b1, 2'b00, 0, 1'b0, 1'b0, 1'b0, ex(0, 0, 0, 0, 0, 0, 0, 0));
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front(); o = q_obs.pop_front(); n_tot++;
      if (o !== e) $display("FAIL reset: got=%b required=%b (credit,troco,tv,lib,cmp,rej,neg,ocu)", o, e);
      else n_pass++;
    end
  endtask

  task automatic test_coins;
    cyc(1'b1, 2'b01, 0, 1'b0, 1'b0, 1'b0, ex(1, 0, 0, 0, 0, 0, 0, 0));
    cyc(1'b1, 2'b10, 0, 1'b0, 1'b0, 1'b0, ex(3, 0, 0, 0, 0, 0, 0, 0));
    cyc(1'b1, 2'b11, 0, 1'b0, 1'b0, 1'b0, ex(7, 0, 0, 0, 0, 0, 0, 0));
    cyc(1'b1, 2'b11, 0, 1'b0, 1'b0, 1'b0, ex(7, 0, 0, 0, 0, 1, 0, 0));
    cyc(1'b1, 2'b01, 0, 1'b0, 1'b0, 1'b0, ex(8, 0, 0, 0, 0, 0, 0, 0));
    cyc(1'b1, 2'b01, 0, 1'b0, 1'b0, 1'b0, ex(8, 0, 0, 0, 0, 1, 0, 0));
    cyc(1'b0, 2'b00, 0, 1'b0, 1'b1, 1'b0, ex(0, 8, 1, 0, 0, 0, 0, 1));
    idle(ex(0, 8, 0, 0, 0, 0, 0, 0));
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front(); o = q_obs.pop_front(); n_tot++;
      if (o !== e) $display("FAIL coins_ceiling: got=%b required=%b (credit,troco,tv,lib,cmp,rej,neg,ocu)", o, e);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    cyc(1'b1, 2'b11, 0, 1'b0, 1'b0, 1'b0, ex(4, 8, 0, 0, 0, 0, 0, 0));
    cyc(1'b1, 2'b10, 0, 1'b0, 1'b0, 1'b0, ex(6, 8, 0, 0, 0, 0, 0, 0));
    cyc(1'b1, 2'b01, 0, 1'b0, 1'b0, 1'b0, ex(7, 8, 0, 0, 0, 0, 0, 0));
    cyc(1'b0, 2'b00, 5, 1'b1, 1'b0, 1'b0, ex(0, 2, 1, 1, 0, 0, 0, 1));
    // Coin and a free compra while VENDA is settling: coin bounced, compra ignored.
    cyc(1'b1, 2'b01, 0, 1'b1, 1'b0, 1'b0, ex(0, 2, 0, 0, 0, 1, 0, 0));
    idle(ex(0, 2, 0, 0, 0, 0, 0, 0));
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front(); o = q_obs.pop_front(); n_tot++;
      if (o !== e) $display("FAIL sale: got=%b required=%b (credit,troco,tv,lib,cmp,rej,neg,ocu)", o, e);
      else n_pass++;
    end
  endtask

  task automatic test_denied;
    cyc(1'b0, 2'b00, 3, 1'b1, 1'b0, 1'b0, ex(0, 2, 0, 0, 0, 0, 1, 0));
    cyc(1'b1, 2'b10, 0, 1'b0, 1'b0, 1'b0, ex(2, 2, 0, 0, 0, 0, 0, 0));
    cyc(1'b1, 2'b01, 0, 1'b0, 1'b0, 1'b0, ex(3, 2, 0, 0, 0, 0, 0, 0));
    cyc(1'b0, 2'b00, 6, 1'b1, 1'b0, 1'b0, ex(3, 2, 0, 0, 0, 0, 1, 0));
    cyc(1'b1, 2'b11, 0, 1'b0, 1'b0, 1'b0, ex(7, 2, 0, 0, 0, 0, 0, 0));
    cyc(1'b0, 2'b00, 6, 1'b1, 1'b0, 1'b0, ex(0, 1, 1, 1, 0, 0, 0, 1));
    idle(ex(0, 1, 0, 0, 0, 0, 0, 0));
    cyc(1'b0, 2'b00, 0, 1'b1, 1'b0, 1'b0, ex(0, 0, 1, 1, 0, 0, 0, 1));
    idle(ex(0, 0, 0, 0, 0, 0, 0, 0));
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front(); o = q_obs.pop_front(); n_tot++;
      if (o !== e) $display("FAIL denied: got=%b required=%b (credit,troco,tv,lib,cmp,rej,neg,ocu)", o, e);
      else n_pass++;
    end
  endtask

  task automatic test_timeout;
    cyc(1'b1, 2'b10, 0, 1'b0, 1'b0, 1'b0, ex(2, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 9; i++) idle(ex(2, 0, 0, 0, 0, 0, 0, 0));
    idle(ex(0, 2, 1, 0, 1, 0, 0, 1));
    idle(ex(0, 2, 0, 0, 0, 0, 0, 0));
    cyc(1'b1, 2'b01, 0, 1'b0, 1'b0, 1'b0, ex(1, 2, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) idle(ex(1, 2, 0, 0, 0, 0, 0, 0));
    cyc(1'b1, 2'b01, 0, 1'b0, 1'b0, 1'b0, ex(2, 2, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 9; i++) idle(ex(2, 2, 0, 0, 0, 0, 0, 0));
    cyc(1'b1, 2'b01, 0, 1'b0, 1'b0, 1'b0, ex(0, 2, 1, 0, 1, 1, 0, 1));
    idle(ex(0, 2, 0, 0, 0, 0, 0, 0));
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front(); o = q_obs.pop_front(); n_tot++;
      if (o !== e) $display("FAIL timeout: got=%b required=%b (credit,troco,tv,lib,cmp,rej,neg,ocu)", o, e);
      else n_pass++;
    end
  endtask

  task automatic test_priority;
    cyc(1'b1, 2'b11, 0, 1'b0, 1'b0, 1'b0, ex(4, 2, 0, 0, 0, 0, 0, 0));
    cyc(1'b1, 2'b01, 1, 1'b1, 1'b1, 1'b0, ex(0, 4, 1, 0, 0, 1, 0, 1));
    idle(ex(0, 4, 0, 0, 0, 0, 0, 0));
    cyc(1'b1, 2'b10, 0, 1'b0, 1'b0, 1'b0, ex(2, 4, 0, 0, 0, 0, 0, 0));
    cyc(1'b0, 2'b00, 0, 1'b0, 1'b1, 1'b1, ex(0, 0, 0, 0, 0, 0, 0, 0));
    idle(ex(0, 0, 0, 0, 0, 0, 0, 0));
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front(); o = q_obs.pop_front(); n_tot++;
      if (o !== e) $display("FAIL priority_reset: got=%b required=%b (credit,troco,tv,lib,cmp,rej,neg,ocu)", o, e);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset;
    test_coins;
    test_back_to_back;
    test_denied;
    test_timeout;
    test_priority;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/acumulador_credito.md
Name: acumulador_credito

Overview:
Parametrised coin-credit accumulator for the vending machine. It adds validated coin values to a credit register and rejects any coin that would exceed the credit ceiling. It runs its own inactivity timeout and settles each session with a sale (dispense plus change) or a full refund. It sits between the coin-validator front end and the product/change dispensers.

Parameters:
CREDIT_W, 8, width of credit, price and change buses (units of R$0,25)
MAX_CREDIT, 8, credit ceiling in units (8 = R$2,00); must be < 2**CREDIT_W
COIN1_VAL, 1, value of valorMoeda=2'b01 in units
COIN2_VAL, 2, value of valorMoeda=2'b10 in units
COIN3_VAL, 4, value of valorMoeda=2'b11 in units
TIMEOUT_CYC, 1000, idle cycles in ACUM before automatic refund (>=2)

Ports:
clk  in  1  single system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
moeda_valida  in  1  one-cycle strobe; valorMoeda valid this cycle
valorMoeda  in  2  coin code; 2'b00 = no coin
preco  in  CREDIT_W  selected product price, sampled on compra
compra  in  1  purchase request strobe
cancelar  in  1  refund request strobe
valorAcumulado  out  CREDIT_W  current credit
comparar  out  1  one-cycle pulse: session ended by timeout
liberar  out  1  one-cycle pulse: dispense product
troco  out  CREDIT_W  change/refund amount, valid with troco_valido
troco_valido  out  1  one-cycle pulse
moeda_rejeitada  out  1  one-cycle pulse: coin returned, credit unchanged
compra_negada  out  1  one-cycle pulse: compra with credit < preco
ocupado  out  1  high in VENDA/DEVOLVE

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset: state=IDLE; valorAcumulado=0; timer=0; all pulse outputs=0; troco=0; ocupado=0. Reset mid-session discards credit and issues no refund pulse.
- All outputs are registered. Effects are visible in the cycle after the input edge.
- States:
  - IDLE: credit=0.
  - ACUM: credit>0, timer running.
  - VENDA: 1 cycle.
  - DEVOLVE: 1 cycle.
- Coin acceptance (IDLE/ACUM, no higher-priority event): v=COINn_VAL.
  - If credit+v <= MAX_CREDIT: credit += v, timer cleared, go to ACUM.
  - Else: moeda_rejeitada=1 and credit unchanged. No wrap-to-zero.
  - The sum is computed at CREDIT_W+1 bits.
- moeda_valida with valorMoeda=2'b00: ignored, no pulse.
- Priority in one cycle: rst > cancelar > compra > timeout > coin. A coin strobe coinciding with a terminal event (cancelar, accepted compra, timeout) is rejected (moeda_rejeitada=1).
- cancelar in ACUM: go to DEVOLVE, troco=credit, troco_valido=1, credit->0. In IDLE: ignored.
- compra in ACUM/IDLE:
  - credit >= preco: go to VENDA, liberar=1, troco=credit-preco, troco_valido=1 (even when troco=0), credit->0.
  - credit < preco: compra_negada=1, state/credit/timer unchanged.
  - preco=0 in IDLE is a free sale (liberar=1, troco=0).
- Timeout: the timer increments each ACUM cycle without an accepted coin. When timer reaches TIMEOUT_CYC-1: go to DEVOLVE, comparar=1, troco=credit, troco_valido=1, credit->0. The timer is held at 0 outside ACUM.
- VENDA/DEVOLVE: ocupado=1. Every coin strobe is rejected and compra/cancelar are ignored. Next state is always IDLE.
- troco holds its last value until the next troco_valido. Only troco_valido qualifies it.
- Exact fill to MAX_CREDIT is accepted. Credit never exceeds MAX_CREDIT.

Test Plan:
1. rst, then coins 01,10,11 on separate cycles -> valorAcumulado 1,3,7. No rejections.
2. Credit 7, coin 11 -> moeda_rejeitada pulse, credit stays 7. Then coin 01 -> credit 8 (exact ceiling).
3. Credit 7, preco=5, compra -> next cycle liberar=1, troco=2, troco_valido=1, ocupado=1. Cycle after: IDLE, credit 0.
4. Credit 3, preco=6, compra -> compra_negada=1, credit 3. Add coin 11 (credit 7), compra -> liberar, troco=1.
5. TIMEOUT_CYC=10, coin 10 then idle -> comparar=1, troco=2, troco_valido=1 exactly 10 cycles after acceptance. A coin at cycle 5 restarts the count.
6. Same-cycle cancelar+compra+coin with credit 4 -> refund troco=4, moeda_rejeitada=1, liberar=0. rst asserted in ACUM -> credit 0 next cycle, no troco_valido.
